// File: rtl/uart_rx_unit.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_unit
// Description : Oversampling UART receiver. Deserialises the i_rx line into
//               NB_DATA-bit words (LSB first) using N_TICKS baud ticks per
//               bit. Frames with a low stop bit are flagged and dropped, and
//               a line held low afterwards (break) is absorbed until it
//               returns high.
//
// Ports       : i_clk          system clock
//               i_reset        synchronous, active-low reset
//               i_tick         one-cycle baud-tick strobe (N_TICKS x baud)
//               i_rx           asynchronous serial input, idle high
//               o_data         last good received word
//               o_rx_done      one-cycle pulse, o_data just updated
//               o_frame_error  one-cycle pulse, stop bit sampled low
//
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_unit #(
  parameter int NB_DATA     = 8,
  parameter int N_TICKS     = 16,
  parameter int NB_TICK_CNT = 4,
  parameter int NB_BIT_CNT  = 3
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_tick,
  input  logic               i_rx,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_rx_done,
  output logic               o_frame_error
);

  // Tick on which the start bit is re-checked (its middle).
  localparam logic [NB_TICK_CNT-1:0] c_half_tick = NB_TICK_CNT'(N_TICKS / 2 - 1);
  // Tick on which data/stop bits are sampled (one full bit after the
  // previous sample, i.e. mid-bit).
  localparam logic [NB_TICK_CNT-1:0] c_last_tick = NB_TICK_CNT'(N_TICKS - 1);
  localparam logic [NB_TICK_CNT-1:0] c_tick_one  = NB_TICK_CNT'(1);
  localparam logic [NB_BIT_CNT-1:0]  c_last_bit  = NB_BIT_CNT'(NB_DATA - 1);
  localparam logic [NB_BIT_CNT-1:0]  c_bit_one   = NB_BIT_CNT'(1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

  state_t                 state_q;
  logic                   rx_meta_q;
  logic                   rx_sync_q;
  logic [NB_TICK_CNT-1:0] s_q;
  logic [NB_BIT_CNT-1:0]  n_q;
  logic [NB_DATA-1:0]     b_q;
  logic [NB_DATA-1:0]     data_q;
  logic                   rx_done_q;
  logic                   frame_err_q;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      // Synchroniser resets to the idle line level so no false start
      // edge is seen when reset is released.
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      state_q     <= ST_IDLE;
      s_q         <= '0;
      n_q         <= '0;
      b_q         <= '0;
      data_q      <= '0;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_meta_q   <= i_rx;
      rx_sync_q   <= rx_meta_q;
      // Status outputs are single-cycle pulses.
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          // Falling edge detected without waiting for a tick; the tick
          // counter starts from here.
          if (!rx_sync_q) begin
            state_q <= ST_START;
            s_q     <= '0;
          end
        end

        ST_START: begin
          if (i_tick) begin
            if (s_q == c_half_tick) begin
              if (!rx_sync_q) begin
                state_q <= ST_DATA;
                s_q     <= '0;
                n_q     <= '0;
              end else begin
                // Line back high at mid-start: treat as a glitch.
                state_q <= ST_IDLE;
              end
            end else begin
              s_q <= s_q + c_tick_one;
            end
          end
        end

        ST_DATA: begin
          if (i_tick) begin
            if (s_q == c_last_tick) begin
              s_q <= '0;
              b_q <= {rx_sync_q, b_q[NB_DATA-1:1]};
              if (n_q == c_last_bit) begin
                state_q <= ST_STOP;
              end else begin
                n_q <= n_q + c_bit_one;
              end
            end else begin
              s_q <= s_q + c_tick_one;
            end
          end
        end

        ST_STOP: begin
          if (i_tick) begin
            if (s_q == c_last_tick) begin
              if (rx_sync_q) begin
                data_q    <= b_q;
                rx_done_q <= 1'b1;
                state_q   <= ST_IDLE;
              end else begin
                // Bad stop bit: keep the previous word, wait out the
                // low line before looking for a new start edge.
                frame_err_q <= 1'b1;
                state_q     <= ST_BREAK;
              end
            end else begin
              s_q <= s_q + c_tick_one;
            end
          end
        end

        ST_BREAK: begin
          if (rx_sync_q) begin
            state_q <= ST_IDLE;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_data        = data_q;
  assign o_rx_done     = rx_done_q;
  assign o_frame_error = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_unit
// Description : Self-checking bench for uart_rx_unit. A behavioural model
//               counts baud ticks from each detected start edge and samples
//               the line at N/2 + k*N ticks; every cycle its outputs are
//               compared with the DUT. A scoreboard of transmitted good words
//               and literal checks per directed scenario pin the model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_unit;

  localparam int NB = 8;
  localparam int NT = 16;

  logic          clk;
  logic          i_reset;
  logic          i_tick;
  logic          i_rx;
  logic [NB-1:0] o_data;
  logic          o_rx_done;
  logic          o_frame_error;

  uart_rx_unit #(
    .NB_DATA    (NB),
    .N_TICKS    (NT),
    .NB_TICK_CNT(4),
    .NB_BIT_CNT (3)
  ) u_dut (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .i_tick       (i_tick),
    .i_rx         (i_rx),
    .o_data       (o_data),
    .o_rx_done    (o_rx_done),
    .o_frame_error(o_frame_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  bit chk_en   = 1'b0;

  // Clocks per baud tick; a short period keeps the run brief.
  int period   = 4;
  bit tick_rnd = 1'b0;

  logic [NB-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // --------------------------------------------------------------------------
  // Tick generator
  // --------------------------------------------------------------------------
  initial begin
    int tcnt;
    tcnt   = 0;
    i_tick = 1'b0;
    forever begin
      @(negedge clk);
      if (tick_rnd) begin
        i_tick = 1'($urandom_range(0, 1));
      end else if (tcnt >= period - 1) begin
        i_tick = 1'b1;
        tcnt   = 0;
      end else begin
        i_tick = 1'b0;
        tcnt++;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Behavioural model: line seen two clocks late; after a start edge the
  // ticks are counted and the line is sampled at NT/2 (start check) and at
  // NT/2 + k*NT for k = 1..NB (data) and k = NB+1 (stop).
  // --------------------------------------------------------------------------
  logic [NB-1:0] m_data;
  logic          m_done;
  logic          m_err;

  initial begin
    logic          h1, h2, rxs;
    logic [NB-1:0] bits;
    int            mode;   // 0 waiting for edge, 1 in frame, 2 line held low
    int            t, k;
    h1 = 1'b1; h2 = 1'b1; mode = 0; t = 0; bits = '0;
    m_data = '0; m_done = 1'b0; m_err = 1'b0;
    forever begin
      @(posedge clk);
      if (!i_reset) begin
        h1 = 1'b1; h2 = 1'b1; mode = 0; t = 0; bits = '0;
        m_data = '0; m_done = 1'b0; m_err = 1'b0;
      end else begin
        rxs    = h2;
        m_done = 1'b0;
        m_err  = 1'b0;
        if (mode == 0) begin
          if (!rxs) begin mode = 1; t = 0; end
        end else if (mode == 1) begin
          if (i_tick) begin
            t++;
            if (t == NT / 2) begin
              if (rxs) mode = 0;
            end else if (t > NT / 2 && (t - NT / 2) % NT == 0) begin
              k = (t - NT / 2) / NT;
              if (k <= NB) begin
                bits[k-1] = rxs;
              end else if (rxs) begin
                m_data = bits; m_done = 1'b1; mode = 0;
              end else begin
                m_err = 1'b1; mode = 2;
              end
            end
          end
        end else begin
          if (rxs) mode = 0;
        end
        h2 = h1;
        h1 = i_rx;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Per-cycle compare and scoreboard
  // --------------------------------------------------------------------------
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("rx_done", 32'(o_rx_done), 32'(m_done));
        check("frame_error", 32'(o_frame_error), 32'(m_err));
        check("data", 32'(o_data), 32'(m_data));
        check("exclusive", 32'(o_rx_done & o_frame_error), 32'd0);
        if (o_rx_done === 1'b1) begin
          done_cnt++;
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL scoreboard: unexpected word %0h, none pending", o_data);
          end else begin
            check("scoreboard", 32'(o_data), 32'(exp_q.pop_front()));
          end
        end
        if (o_frame_error === 1'b1) err_cnt++;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Line driver helpers (all start right after a falling clock edge)
  // --------------------------------------------------------------------------
  task automatic send_bit(input logic b);
    i_rx = b;
    repeat (NT * period) @(negedge clk);
  endtask

  task automatic idle_bits(input int n);
    repeat (n) send_bit(1'b1);
  endtask

  task automatic send_frame(input logic [NB-1:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < NB; i++) send_bit(d[i]);
    send_bit(stop);
  endtask

  task automatic send_good(input logic [NB-1:0] d);
    exp_q.push_back(d);
    send_frame(d, 1'b1);
  endtask

  task automatic glitch(input int ticks);
    i_rx = 1'b0;
    repeat (ticks * period) @(negedge clk);
    i_rx = 1'b1;
  endtask

  // Watchdog: the stimulus is fixed-length, this only guards against a hang.
  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Main sequence
  // --------------------------------------------------------------------------
  initial begin
    int d0, e0, n_good, n_bad;
    logic [NB-1:0] rd;
    n_good = 0; n_bad = 0;
    i_reset = 1'b0;
    i_rx    = 1'b1;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;

    // Reset values while the inputs toggle.
    tick_rnd = 1'b1;
    repeat (30) begin
      i_rx = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("reset_data", 32'(o_data), 32'd0);
      check("reset_done", 32'(o_rx_done), 32'd0);
      check("reset_ferr", 32'(o_frame_error), 32'd0);
    end
    tick_rnd = 1'b0;
    i_rx = 1'b1;
    @(negedge clk);
    i_reset = 1'b1;
    idle_bits(2);

    // Single good frame.
    d0 = done_cnt; e0 = err_cnt;
    send_good(8'hA5); n_good++;
    idle_bits(1);
    check("t1_data", 32'(o_data), 32'hA5);
    check("t1_done_cnt", 32'(done_cnt - d0), 32'd1);
    check("t1_err_cnt", 32'(err_cnt - e0), 32'd0);

    // Back-to-back frames.
    d0 = done_cnt; e0 = err_cnt;
    send_good(8'h00); send_good(8'hFF); send_good(8'h3C); n_good += 3;
    idle_bits(1);
    check("t2_data", 32'(o_data), 32'h3C);
    check("t2_done_cnt", 32'(done_cnt - d0), 32'd3);
    check("t2_err_cnt", 32'(err_cnt - e0), 32'd0);

    // Bad stop bit, then a held-low line.
    send_good(8'h11); n_good++;
    d0 = done_cnt; e0 = err_cnt;
    send_frame(8'h3C, 1'b0); n_bad++;
    i_rx = 1'b0;
    repeat (3 * NT * period) @(negedge clk);
    check("t3_data_kept", 32'(o_data), 32'h11);
    check("t3_err_cnt", 32'(err_cnt - e0), 32'd1);
    check("t3_done_cnt", 32'(done_cnt - d0), 32'd0);
    idle_bits(1);
    send_good(8'h5A); n_good++;
    idle_bits(1);
    check("t3_next_data", 32'(o_data), 32'h5A);

    // Start glitch.
    d0 = done_cnt; e0 = err_cnt;
    glitch(4);
    idle_bits(2);
    check("t4_glitch_done", 32'(done_cnt - d0), 32'd0);
    check("t4_glitch_err", 32'(err_cnt - e0), 32'd0);
    send_good(8'h81); n_good++;
    idle_bits(1);
    check("t4_next_data", 32'(o_data), 32'h81);

    // Reset during data bit 4 of 0xC3; the rest of that frame is abandoned.
    d0 = done_cnt; e0 = err_cnt;
    rd = 8'hC3;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(rd[i]);
    i_rx = rd[4];
    repeat (NT * period / 2) @(negedge clk);
    i_reset = 1'b0;
    @(negedge clk);
    check("t5_rst_data", 32'(o_data), 32'd0);
    check("t5_rst_done", 32'(o_rx_done), 32'd0);
    check("t5_rst_ferr", 32'(o_frame_error), 32'd0);
    @(negedge clk);
    i_rx = 1'b1;
    i_reset = 1'b1;
    idle_bits(2);
    check("t5_abort_done", 32'(done_cnt - d0), 32'd0);
    check("t5_abort_err", 32'(err_cnt - e0), 32'd0);
    send_good(8'h7E); n_good++;
    idle_bits(1);
    check("t5_next_data", 32'(o_data), 32'h7E);

    // Tick held high every cycle.
    period = 1;
    send_good(8'h96); n_good++;
    idle_bits(1);
    check("tick_every_cycle_data", 32'(o_data), 32'h96);

    // Randomised traffic: varying tick rate, gaps, bad stops and glitches.
    for (int f = 0; f < 24; f++) begin
      period = $urandom_range(1, 6);
      if ($urandom_range(0, 5) == 0) begin
        glitch($urandom_range(1, 4));
        idle_bits(1);
      end
      rd = 8'($urandom);
      if ($urandom_range(0, 5) == 0) begin
        send_frame(rd, 1'b0); n_bad++;
        i_rx = 1'b0;
        repeat ($urandom_range(0, 2) * NT * period) @(negedge clk);
        idle_bits(1);
      end else begin
        send_good(rd); n_good++;
        idle_bits($urandom_range(0, 2));
      end
    end
    idle_bits(2);

    check("final_pending", 32'(exp_q.size()), 32'd0);
    check("final_good_cnt", 32'(done_cnt), 32'(n_good));
    check("final_bad_cnt", 32'(err_cnt), 32'(n_bad));

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
